uart_string_sequencer: RTL and testbench
========================================

Name: uart_string_sequencer

Overview:
- Sequences a wide display string (e.g. the rendered 2048 board text) into the byte-wide UART transmitter, one character at a time.
- Holds off on the transmitter's busy handshake and stops at the first NUL or at MAX_CHARS.
- Sits between the board-to-string renderer and uart_top's TX strobe/data inputs.
- Replaces tying a button directly to the TX strobe.

Parameters:
- MAX_CHARS, 625: capacity of the string bus in characters (8*MAX_CHARS bits).
- CW, $clog2(MAX_CHARS+3): width of the character counter.
- ACK_WAIT, 3: maximum cycles to wait for i_tx_busy to rise after a strobe before treating the byte as accepted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to transmit i_string; honoured only in IDLE.
- i_string  in  8*MAX_CHARS  packed characters; char k at bits [8*(MAX_CHARS-k)-1 -: 8], char 0 sent first.
- i_tx_busy  in  1  UART transmitter busy.
- o_tx_data  out  8  byte to UART; stable while o_tx_stb is high and until the next strobe.
- o_tx_stb  out  1  one-cycle send strobe to UART.
- o_busy  out  1  high from accepted start until done.
- o_done  out  1  one-cycle pulse when the sequence completes.
- o_count  out  CW  characters strobed in the current/last sequence.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State becomes IDLE.
  - o_tx_stb=0, o_done=0, o_busy=0, o_tx_data=8'h00, o_count=0.
  - Internal string copy and index are cleared.
  - Reset mid-sequence aborts immediately; the byte already in the UART is not recalled.
- All outputs are registered.
- States:
  - IDLE: on i_start=1, latch i_string into an internal buffer, clear index and o_count, set o_busy=1, go to FETCH. The latched copy decouples the sequence from later i_string changes.
  - FETCH: select char[index].
    - If index==MAX_CHARS or char==8'h00, go to FIN.
    - Else if i_tx_busy=0, drive o_tx_data=char, pulse o_tx_stb for exactly one cycle, increment index and o_count, go to WAIT_HI.
    - Else stay in FETCH.
  - WAIT_HI: wait for i_tx_busy=1, then go to WAIT_LO. If it has not risen after ACK_WAIT cycles, go to FETCH (covers a UART that finishes within the window or never asserts busy).
  - WAIT_LO: wait for i_tx_busy=0, then go to FETCH.
  - FIN: pulse o_done for one cycle, clear o_busy, go to IDLE.
- Latency:
  - First strobe goes high in the second cycle after i_start is sampled (IDLE→FETCH→strobe), provided i_tx_busy=0.
  - At most one strobe per UART busy period; never two strobes without an intervening FETCH.
- Boundaries:
  - First char NUL: no strobe. o_done pulses 2 cycles after start; o_count=0.
  - All MAX_CHARS chars non-NUL: exactly MAX_CHARS strobes, then done. Index never wraps.
  - i_start while o_busy=1: ignored, with no effect on buffer or counter.
  - i_start in the same cycle as o_done: ignored (state is still FIN).
  - i_tx_busy high at start: sequencer holds in FETCH with no strobe until busy falls.
- o_count saturates at its maximum width; it is held after done until the next accepted start.

Optional Feature:
- Macro: UART_SEQ_CRLF_APPEND_EN.
- Defined: on the terminating condition (NUL or MAX_CHARS), the sequencer sends 8'h0D then 8'h0A with the same FETCH/WAIT handshake before FIN. o_count includes both bytes. A zero-length string still sends CR LF.
- Undefined: no trailer; FIN follows the last string character directly. o_count never exceeds MAX_CHARS.

Test Plan:
- Reset mid-sequence: start "HELLO", assert rst after the 2nd strobe → next cycle o_busy=0, o_tx_stb=0, o_count=0; no further strobes.
- Normal string: i_string="ABC" followed by NUL, UART model busy for 10 cycles after each strobe → exactly 3 strobes with data 8'h41, 8'h42, 8'h43, each only while i_tx_busy=0; one o_done pulse; o_count=3. With UART_SEQ_CRLF_APPEND_EN: 5 strobes ending 8'h0D, 8'h0A; o_count=5.
- Empty string: char0=8'h00, start → no strobe; o_done pulse 2 cycles after start; o_count=0 (CRLF build: 2 strobes, o_count=2).
- Full buffer: MAX_CHARS=4, i_string="WXYZ", no NUL → 4 strobes, then done; index does not wrap and no 5th strobe.
- Busy stall and ignored start: hold i_tx_busy=1 for 20 cycles at start → no strobe until release. Pulse i_start and change i_string mid-sequence → transmitted bytes unchanged; the original sequence completes once.
- Silent UART: i_tx_busy tied 0 → WAIT_HI times out after ACK_WAIT=3 cycles per byte; "AB" yields strobes 5 cycles apart; done asserted.

Source files
------------

// File: rtl/uart_string_sequencer_if.sv
// rtl/uart_string_sequencer_if.sv - string-in / UART-byte-out handshake bundle for uart_string_sequencer
// master: the sequencer side; slave: renderer/UART side.
interface uart_string_sequencer_if #(
  parameter int MAX_CHARS = 625,
  parameter int CW        = $clog2(MAX_CHARS + 3)
);
  logic                   i_start;
  logic [8*MAX_CHARS-1:0] i_string;
  logic                   i_tx_busy;
  logic [7:0]             o_tx_data;
  logic                   o_tx_stb;
  logic                   o_busy;
  logic                   o_done;
  logic [CW-1:0]          o_count;

  modport master (
    input  i_start, i_string, i_tx_busy,
    output o_tx_data, o_tx_stb, o_busy, o_done, o_count
  );

  modport slave (
    output i_start, i_string, i_tx_busy,
    input  o_tx_data, o_tx_stb, o_busy, o_done, o_count
  );
endinterface

// File: rtl/uart_string_sequencer.sv
// rtl/uart_string_sequencer.sv - feeds a latched wide string into a byte UART, one char per busy period
// Optional CR LF trailer when UART_SEQ_CRLF_APPEND_EN is defined.
module uart_string_sequencer #(
  parameter int MAX_CHARS = 625,
  parameter int CW        = $clog2(MAX_CHARS + 3),
  parameter int ACK_WAIT  = 3
) (
  input logic                     clk,
  input logic                     rst,
  uart_string_sequencer_if.master bus
);
  localparam int            WW      = $clog2(ACK_WAIT + 1);
  localparam logic [CW-1:0] LP_MAX  = CW'(MAX_CHARS);
  localparam logic [WW-1:0] LP_WAIT = WW'(ACK_WAIT);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_HI, S_WAIT_LO, S_FIN} state_t;

  state_t                 r_state, w_state_nx;
  logic [8*MAX_CHARS-1:0] r_buf, w_buf_nx;
  logic [CW-1:0]          r_index, w_index_nx;
  logic [CW-1:0]          r_count, w_count_nx;
  logic [WW-1:0]          r_wait, w_wait_nx;
  logic [7:0]             r_tx_data, w_tx_data_nx;
  logic                   r_tx_stb, w_tx_stb_nx;
  logic                   r_busy, w_busy_nx;
  logic                   r_done, w_done_nx;

  logic [7:0] w_head;
  logic       w_term;
  logic [7:0] w_send_char;
  logic       w_send_ok;
  logic       w_is_str;

  // The buffer shifts left on every sent string char, so the head is always the next char.
  assign w_head = r_buf[8*MAX_CHARS-1 -: 8];
  assign w_term = (r_index == LP_MAX) || (w_head == 8'h00);

`ifdef UART_SEQ_CRLF_APPEND_EN
  logic [1:0] r_phase;

  always_comb begin
    w_send_char = w_head;
    w_send_ok   = !w_term;
    w_is_str    = 1'b1;
    if (r_phase == 2'd1) begin
      w_send_char = 8'h0A;
      w_send_ok   = 1'b1;
      w_is_str    = 1'b0;
    end else if (r_phase == 2'd2) begin
      w_send_ok   = 1'b0;
      w_is_str    = 1'b0;
    end else if (w_term) begin
      w_send_char = 8'h0D;
      w_send_ok   = 1'b1;
      w_is_str    = 1'b0;
    end
  end

  // Trailer phase: 0 string, 1 LF pending, 2 trailer sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 2'd0;
    end else if (r_state == S_IDLE && bus.i_start) begin
      r_phase <= 2'd0;
    end else if (r_state == S_FETCH && w_send_ok && !w_is_str && !bus.i_tx_busy) begin
      r_phase <= r_phase + 2'd1;
    end
  end
`else
  always_comb begin
    w_send_char = w_head;
    w_send_ok   = !w_term;
    w_is_str    = 1'b1;
  end
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_buf_nx     = r_buf;
    w_index_nx   = r_index;
    w_count_nx   = r_count;
    w_wait_nx    = r_wait;
    w_tx_data_nx = r_tx_data;
    w_tx_stb_nx  = 1'b0;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_buf_nx   = bus.i_string;
          w_index_nx = '0;
          w_count_nx = '0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!w_send_ok) begin
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_FIN;
        end else if (!bus.i_tx_busy) begin
          w_tx_data_nx = w_send_char;
          w_tx_stb_nx  = 1'b1;
          if (w_is_str) begin
            w_buf_nx   = r_buf << 8;
            w_index_nx = r_index + 1'b1;
          end
          w_count_nx = (r_count == '1) ? r_count : r_count + 1'b1;
          w_wait_nx  = '0;
          w_state_nx = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // A UART that never raises busy (or finishes inside the window) releases us here.
        if (bus.i_tx_busy) begin
          w_state_nx = S_WAIT_LO;
        end else if (r_wait == LP_WAIT) begin
          w_state_nx = S_FETCH;
        end else begin
          w_wait_nx = r_wait + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.i_tx_busy) begin
          w_state_nx = S_FETCH;
        end
      end
      S_FIN: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_index   <= '0;
      r_count   <= '0;
      r_wait    <= '0;
      r_tx_data <= 8'h00;
      r_tx_stb  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_buf     <= w_buf_nx;
      r_index   <= w_index_nx;
      r_count   <= w_count_nx;
      r_wait    <= w_wait_nx;
      r_tx_data <= w_tx_data_nx;
      r_tx_stb  <= w_tx_stb_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
    end
  end

  assign bus.o_tx_data = r_tx_data;
  assign bus.o_tx_stb  = r_tx_stb;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_count   = r_count;
endmodule

// File: tb/tb_uart_string_sequencer.sv
// tb/tb_uart_string_sequencer.sv - randomized self-checking bench for uart_string_sequencer
module tb_uart_string_sequencer;
  localparam int MC = 8;
  localparam int CW = $clog2(MC + 3);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_string_sequencer_if #(.MAX_CHARS(MC), .CW(CW)) bus ();
  uart_string_sequencer #(.MAX_CHARS(MC), .CW(CW), .ACK_WAIT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART model: busy for busy_len cycles after each strobe; busy_len 0 means it never asserts busy.
  int busy_len  = 10;
  bit hold_busy = 1'b0;
  initial begin
    int rem;
    rem = 0;
    bus.i_tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.o_tx_stb && busy_len > 0) rem = busy_len;
      bus.i_tx_busy = hold_busy || (rem > 0);
      if (rem > 0) rem--;
    end
  end

  // Monitor: edge-numbered record of strobes, starts and done pulses.
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;
  int         stb_cyc[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       prev_stb = 1'b0;
  logic       prev_done = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.i_start) start_cyc = cyc;
      if (bus.o_tx_stb) begin
        got_q.push_back(bus.o_tx_data);
        stb_cyc.push_back(cyc);
        check_eq("stb_while_busy", 32'(bus.i_tx_busy), 32'd0);
        check_eq("stb_back_to_back", 32'(prev_stb), 32'd0);
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_width", 32'(prev_done), 32'd0);
      end
      prev_stb  = bus.o_tx_stb;
      prev_done = bus.o_done;
    end
  end

  // Reference: chars up to the first NUL or MAX_CHARS, plus the optional CR LF trailer.
  function automatic void build_exp(input logic [7:0] b[MC]);
    exp_q.delete();
    for (int k = 0; k < MC; k++) begin
      if (b[k] == 8'h00) break;
      exp_q.push_back(b[k]);
    end
`ifdef UART_SEQ_CRLF_APPEND_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  task automatic start_seq(input logic [7:0] b[MC]);
    logic [8*MC-1:0] s;
    for (int k = 0; k < MC; k++) s[8*(MC-k)-1 -: 8] = b[k];
    @(negedge clk);
    bus.i_string = s;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start  = 1'b0;
  endtask

  int d0 = 0;

  task automatic begin_run(input logic [7:0] b[MC], input int blen);
    busy_len = blen;
    got_q.delete();
    stb_cyc.delete();
    d0 = done_cnt;
    build_exp(b);
    start_seq(b);
    check_eq("busy_after_start", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic end_run(input string tag);
    for (int i = 0; i < 800; i++) begin
      if (done_cnt > d0) break;
      @(posedge clk); #3;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
    check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq({tag, "_count"}, 32'(bus.o_count), 32'(exp_q.size()));
    check_eq({tag, "_busy_end"}, 32'(bus.o_busy), 32'd0);
    repeat (16) @(posedge clk);
    #3;
    check_eq({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_count_held"}, 32'(bus.o_count), 32'(exp_q.size()));
  endtask

  function automatic void set_str(output logic [7:0] b[MC], input string s);
    for (int k = 0; k < MC; k++)
      b[k] = (k < s.len()) ? 8'(s[k]) : 8'h00;
  endfunction

  logic [7:0] b[MC];
  logic [7:0] b2[MC];

  initial begin
    rst = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_string = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stb", 32'(bus.o_tx_stb), 32'd0);
    check_eq("rst_done", 32'(bus.o_done), 32'd0);
    check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    check_eq("rst_data", 32'(bus.o_tx_data), 32'd0);
    check_eq("rst_count", 32'(bus.o_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal string with bytes after the NUL that must not be sent.
    set_str(b, "ABC");
    b[4] = 8'h55; b[5] = 8'h66;
    begin_run(b, 10);
    end_run("abc");
    check_eq("abc_first_stb_latency", 32'(stb_cyc.size() > 0 ? stb_cyc[0] - start_cyc : -1), 32'd1);

    // Empty string.
    set_str(b, "");
    b[1] = 8'h41;
    begin_run(b, 10);
    end_run("empty");
`ifndef UART_SEQ_CRLF_APPEND_EN
    check_eq("empty_done_latency", 32'(done_cyc - start_cyc), 32'd1);
`endif

    // Full buffer, no NUL.
    set_str(b, "WXYZwxyz");
    begin_run(b, 3);
    end_run("full");

    // Busy held high at start: no strobe until released.
    set_str(b, "STALL");
    hold_busy = 1'b1;
    repeat (2) @(posedge clk);
    begin_run(b, 10);
    repeat (20) @(posedge clk);
    #3;
    check_eq("stall_no_stb", 32'(got_q.size()), 32'd0);
    hold_busy = 1'b0;
    end_run("stall");

    // Start and string change mid-sequence are ignored.
    set_str(b, "QUIET!");
    set_str(b2, "noise");
    begin_run(b, 10);
    repeat (8) @(posedge clk);
    start_seq(b2);
    end_run("ignore");

    // Silent UART: strobes paced only by the ack timeout.
    set_str(b, "AB");
    begin_run(b, 0);
    end_run("silent");
    check_eq("silent_gap", 32'(stb_cyc.size() >= 2 ? stb_cyc[1] - stb_cyc[0] : 0), 32'd5);

    // Randomized strings and UART busy lengths.
    for (int it = 0; it < 25; it++) begin
      int len;
      len = $urandom_range(0, MC);
      for (int k = 0; k < MC; k++) b[k] = 8'($urandom_range(1, 255));
      if (len < MC) b[len] = 8'h00;
      begin_run(b, $urandom_range(0, 6));
      end_run($sformatf("rnd%0d", it));
    end

    // Reset mid-sequence after the second strobe.
    set_str(b, "HELLO");
    begin_run(b, 4);
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() >= 2) break;
      @(posedge clk); #3;
    end
    check_eq("rstmid_two_stb", 32'(got_q.size()), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid_busy", 32'(bus.o_busy), 32'd0);
    check_eq("rstmid_stb", 32'(bus.o_tx_stb), 32'd0);
    check_eq("rstmid_count", 32'(bus.o_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    check_eq("rstmid_no_more_stb", 32'(got_q.size()), 32'd2);
    check_eq("rstmid_idle_busy", 32'(bus.o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
